// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter (start, LSB-first data, optional even parity via UART_TX_PARITY_EN, stop)
module uart_tx #(
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 100_000_000,
    parameter int DATA_BITS = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_serial
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    assign bit_end    = (baud_cnt == CNT_MAX);
    assign shift_next = shreg >> 1;

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_serial <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    baud_cnt  <= '0;
                    if (tx_en) begin
                        shreg     <= tx_data;
                        state     <= START;
                        tx_busy   <= 1'b1;
                        tx_serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity    <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        state     <= DATA;
                        tx_serial <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_MAX) begin
`ifdef UART_TX_PARITY_EN
                            state     <= PARITY;
                            tx_serial <= parity;
`else
                            state     <= STOP;
                            tx_serial <= 1'b1;
`endif
                        end else begin
                            // Shift so the next bit to send always sits at bit 0
                            bit_idx   <= bit_idx + 1'b1;
                            shreg     <= shift_next;
                            tx_serial <= shift_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        state     <= STOP;
                        tx_serial <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        // A request on the done edge chains straight into the next start bit
                        if (tx_en) begin
                            shreg     <= tx_data;
                            state     <= START;
                            tx_busy   <= 1'b1;
                            tx_serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            parity    <= ^tx_data;
`endif
                        end else begin
                            state     <= IDLE;
                            tx_busy   <= 1'b0;
                            tx_serial <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_busy   <= 1'b0;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a per-cycle line model
module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done, tx_serial;

    int checks = 0;
    int errors = 0;

    uart_tx #(.BAUD_RATE(100), .CLK_FREQ(1600), .DATA_BITS(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_serial(tx_serial)
    );

    always #5 PCLK = ~PCLK;

    // k counts negedges after the acceptance edge; k == FRAME is the sample after the done edge
    task automatic check_frame(input logic [7:0] d, input bit chain, input logic [7:0] nd,
                               input int k_start, input bit inject);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        for (int k = k_start; k < FRAME; k++) begin
            @(negedge PCLK);
            checks++;
            if (tx_serial !== bits[k / CPB]) begin
                errors++;
                $display("FAIL serial data=%02h k=%0d got %b exp %b", d, k, tx_serial, bits[k / CPB]);
            end
            checks++;
            if ({tx_busy, tx_done} !== 2'b10) begin
                errors++;
                $display("FAIL busy_done data=%02h k=%0d got %b%b exp 10", d, k, tx_busy, tx_done);
            end
            if (k == 0) tx_en = 1'b0;
            if (inject && k == FRAME / 2) begin tx_en = 1'b1; tx_data = 8'h3C; end
            if (inject && k == FRAME / 2 + 1) begin tx_en = 1'b0; tx_data = 8'hFF; end
            if (chain && k == FRAME - 1) begin tx_en = 1'b1; tx_data = nd; end
        end
        @(negedge PCLK);
        checks++;
        if ({tx_done, tx_busy, tx_serial} !== {1'b1, chain, ~chain}) begin
            errors++;
            $display("FAIL frame_end data=%02h got done/busy/serial %b%b%b exp %b%b%b",
                     d, tx_done, tx_busy, tx_serial, 1'b1, chain, ~chain);
        end
        if (chain) tx_en = 1'b0;
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            checks++;
            if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
                errors++;
                $display("FAIL idle cyc=%0d got serial/busy/done %b%b%b exp 100",
                         i, tx_serial, tx_busy, tx_done);
            end
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge PCLK);
        tx_en = 1'b1;
        tx_data = d;
        check_frame(d, 1'b0, 8'h00, 0, 1'b0);
    endtask

    task automatic test_reset();
        PRESETn = 1'b1;
        repeat (10) @(negedge PCLK);
        checks++;
        if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset got serial/busy/done %b%b%b exp 100", tx_serial, tx_busy, tx_done);
        end
        PRESETn = 1'b0;
        check_idle(20);
    endtask

    task automatic test_known();
        start_tx(8'h0F);
        check_idle(CPB);
        start_tx(8'hEE);
        check_idle(5);
        start_tx(8'hCD);
        check_idle(5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            start_tx(8'($urandom));
            check_idle(int'($urandom_range(1, 20)));
        end
    endtask

    task automatic test_busy();
        @(negedge PCLK);
        tx_en = 1'b1;
        tx_data = 8'hA5;
        check_frame(8'hA5, 1'b0, 8'h00, 0, 1'b1);
        check_idle(3 * CPB);
    endtask

    task automatic test_back_to_back();
        @(negedge PCLK);
        tx_en = 1'b1;
        tx_data = 8'hC3;
        check_frame(8'hC3, 1'b1, 8'h55, 0, 1'b0);
        check_frame(8'h55, 1'b0, 8'h00, 1, 1'b0);
        check_idle(10);
    endtask

    task automatic test_reset_mid();
        @(negedge PCLK);
        tx_en = 1'b1;
        tx_data = 8'h0F;
        @(negedge PCLK);
        tx_en = 1'b0;
        repeat (3 * CPB + CPB / 2) @(negedge PCLK);
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_busy got %b exp 1", tx_busy);
        end
        PRESETn = 1'b1;
        @(negedge PCLK);
        checks++;
        if ({tx_serial, tx_busy, tx_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_abort got serial/busy/done %b%b%b exp 100", tx_serial, tx_busy, tx_done);
        end
        PRESETn = 1'b0;
        check_idle(FRAME + CPB);
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Parallel-to-serial UART transmitter, 8N1 framing by default: 1 start bit (low), DATA_BITS data bits LSB-first, 1 stop bit (high).
- Sits behind the APB UART register block: the register block pulses tx_en with a byte on tx_data and monitors tx_busy/tx_done.
- Bit timing comes from an internal baud counter derived from CLK_FREQ/BAUD_RATE.

Parameters:
- BAUD_RATE, 9600, serial bit rate in bits/s.
- CLK_FREQ, 100_000_000, PCLK frequency in Hz.
- DATA_BITS, 8, data bits per frame.
- Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division). Default value is 10416.

Ports:
- PCLK  input  1  system clock; all logic is on the rising edge.
- PRESETn  input  1  reset. One clock; reset is synchronous and active-high: the block resets at a rising PCLK edge while PRESETn=1, despite the codebase port name.
- tx_en  input  1  start request, sampled at PCLK rising edge.
- tx_data  input  DATA_BITS  byte to send, captured when tx_en is accepted.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  single-cycle pulse at frame completion.
- tx_serial  output  1  serial line; idles high.

Behaviour:
- All outputs are registered.
- Reset values: tx_serial=1, tx_busy=0, tx_done=0. FSM goes to IDLE; baud counter, bit index and shift register are all cleared.
- Reset has priority over everything. Reset mid-frame aborts immediately and the line returns high on the next edge.
- States: IDLE, START, DATA, STOP. Optional PARITY state (see Optional Feature).
- IDLE:
  - tx_serial=1, tx_busy=0.
  - If tx_en=1 at an edge: latch tx_data into the shift register, go to START, set tx_busy=1 and tx_serial=0, all on that same edge.
- START: hold tx_serial=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - Drive tx_serial = latched bit[index] for CLKS_PER_BIT cycles each, index 0..DATA_BITS-1 (LSB first).
  - After the last bit, go to STOP.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - On that same edge: tx_busy=0 and tx_done=1 for one cycle.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on each bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
- Frame length: (2+DATA_BITS)*CLKS_PER_BIT cycles from the acceptance edge to the done edge. Default is 104160 cycles (≈1.0416 ms).
- Ignored inputs:
  - tx_en while tx_busy=1 is ignored (no queueing).
  - tx_data changes after acceptance do not affect the frame in flight.
- tx_en=1 in the same cycle tx_done is asserted (first IDLE cycle) is accepted, giving a back-to-back frame. That edge drives tx_done=1, tx_busy=1, tx_serial=0.
- tx_en held high continuously: a new frame starts at each return to IDLE.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the latched data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (3+DATA_BITS)*CLKS_PER_BIT cycles.
- When undefined: no parity state, 8N1 framing as above.

Test Plan:
- Reset: hold PRESETn=1 for 10 cycles -> tx_serial=1, tx_busy=0, tx_done=0. Release and stay idle 20 cycles -> no change.
- Send 0x0F (1-cycle tx_en):
  - Line samples at bit centers are 0 | 1,1,1,1,0,0,0,0 | 1, each bit 10416 cycles.
  - tx_busy is high for 104160 cycles.
  - tx_done is a 1-cycle pulse at the end.
- Send 0xEE then 0xCD with idle gaps:
  - 0xEE data bits are 0,1,1,1,0,1,1,1.
  - 0xCD data bits are 1,0,1,1,0,0,1,1.
  - Each frame has its own tx_done pulse, and the line is high between frames.
- Busy protection:
  - Start 0xA5, then pulse tx_en with tx_data=0x3C mid-frame -> frame still carries 0xA5 and no second frame follows.
  - Change tx_data mid-frame -> no effect on the frame.
- Back-to-back: assert tx_en with 0x55 in the tx_done cycle -> the next start bit begins on that edge with zero idle cycles.
- Reset mid-frame: assert PRESETn=1 during DATA of 0x0F -> next edge tx_serial=1, tx_busy=0, and no tx_done pulse.
- With UART_TX_PARITY_EN:
  - 0x0F gives parity bit 0 and 0xCD gives parity bit 1.
  - Frame is 114576 cycles.
